alarm_annunciator: RTL
======================

// Module: alarm_annunciator
// PURPOSE
//   Consumer end of the alarm FSM outputs: takes pre_alarm (E2 state) and alarm
//   (E3 state) levels and drives the panel LED, warning buzzer and siren with timed
//   patterns. An ack button silences the siren, but only after a minimum on-time.
//   Sits between fsm_alarma and the board I/O; all outputs are registered.
// PARAMETERS
//   CNT_W       8   width of the internal phase/hold counter
//   BLINK_HALF  4   LED half-period in WARN/SILENCED, in clk cycles (>=1)
//   BEEP_ON     2   buzzer on-cycles per beep period in WARN (>=1)
//   BEEP_OFF    6   buzzer off-cycles per beep period in WARN (>=1)
//   MIN_SIREN   16  minimum cycles siren stays on in ALARM before ack/exit honoured
// PORTS
//   clk        in   1      system clock, rising edge
//   reset      in   1      synchronous, active-high reset
//   pre_alarm  in   1      level from FSM, high while in pre-alarm (E2)
//   alarm      in   1      level from FSM, high while in alarm (E3)
//   ack        in   1      silence request, synchronous level; acts while high
//   led        out  1      panel LED
//   buzzer     out  1      warning buzzer
//   siren      out  1      siren drive
//   state      out  2      00 IDLE, 01 WARN, 10 ALARM, 11 SILENCED
//   event_cnt  out  8      alarm-entry count (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (sampled on clk edge): state=IDLE, led=buzzer=siren=0, counters=0,
//     mute=0, event_cnt=0. Reset mid-pattern aborts immediately, no cleanup cycles.
//   - alarm has priority over pre_alarm when both high.
//   - Latency: inputs sampled at edge N; state and all outputs reflect it after N.
//   - phase counter clears to 0 on every state entry, else increments, wraps at
//     pattern period; hold counter saturates at MIN_SIREN.
//   - IDLE: outputs 0. alarm -> ALARM; else pre_alarm -> WARN.
//   - WARN: led=1 for phase 0..BLINK_HALF-1, 0 for next BLINK_HALF, repeat.
//     buzzer=1 for phase 0..BEEP_ON-1 of each BEEP_ON+BEEP_OFF period unless mute.
//     ack sets mute (buzzer 0 from next cycle); mute clears on leaving WARN.
//     alarm -> ALARM; neither input -> IDLE. siren=0.
//   - ALARM: siren=1, led=1 steady, buzzer=0. hold counts from 0 on entry.
//     ack with hold<MIN_SIREN: ignored (not remembered).
//     ack with hold>=MIN_SIREN -> SILENCED.
//     alarm low with hold<MIN_SIREN: stay in ALARM until hold reaches MIN_SIREN,
//     then go to WARN if pre_alarm else IDLE; alarm low with hold>=MIN_SIREN: same
//     exit immediately. ack and alarm-low together at hold>=MIN_SIREN: exit wins.
//   - SILENCED: siren=0, buzzer=0, led blinks as in WARN. alarm low -> WARN if
//     pre_alarm else IDLE. alarm stays high: remain (no re-arm of siren).
//   - No illegal state reachable; decode default forces IDLE with outputs 0.
// CONFIGURATION
//   ANNUNC_EVENT_COUNT_EN defined: event_cnt is an 8-bit counter incremented on
//     every entry to ALARM, saturating at 255, cleared only by reset.
//   Not defined: no counter logic; event_cnt tied to 8'd0. Port list unchanged.
// TESTING (defaults)
//   reset high 2 cycles -> led=buzzer=siren=0, state=00, event_cnt=0.
//   pre_alarm=1 held 16 cycles -> state=01; led 1111 0000 repeating; buzzer
//     11 000000 repeating; ack 1 cycle at cycle 5 -> buzzer 0 for rest of WARN.
//   alarm=1 at cycle 0, ack=1 cycles 3..5 -> ack ignored, siren=1; ack at cycle 20
//     -> state=11, siren=0 next cycle, led blinking.
//   alarm 1-cycle pulse -> siren=1 exactly MIN_SIREN cycles, then state=00.
//   pre_alarm=1 and alarm=1 together -> state=10; with EN, 3 alarm entries ->
//     event_cnt=3; 300 entries -> 255; without EN -> always 0.
//   reset asserted while in ALARM at hold=5 -> next cycle all outputs 0, state=00.

Source files
------------

// File: rtl/alarm_annunciator_if.sv
// Alarm annunciator bus: FSM levels and ack in, panel drives and status out.
// master = the side driving pre_alarm/alarm/ack; slave = the annunciator.
interface alarm_annunciator_if;
  logic       pre_alarm;
  logic       alarm;
  logic       ack;
  logic       led;
  logic       buzzer;
  logic       siren;
  logic [1:0] state;
  logic [7:0] event_cnt;

  modport master (
    output pre_alarm, alarm, ack,
    input  led, buzzer, siren, state, event_cnt
  );

  modport slave (
    input  pre_alarm, alarm, ack,
    output led, buzzer, siren, state, event_cnt
  );
endinterface

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: turns pre_alarm/alarm levels into LED blink, buzzer beeps
// and siren drive; ack silences the siren once it has been on MIN_SIREN cycles.
// Optional feature macro: ANNUNC_EVENT_COUNT_EN (saturating alarm-entry counter
// on event_cnt; when undefined event_cnt is tied to zero).
module alarm_annunciator #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned BLINK_HALF = 4,
  parameter int unsigned BEEP_ON    = 2,
  parameter int unsigned BEEP_OFF   = 6,
  parameter int unsigned MIN_SIREN  = 16
) (
  input  logic                clk,
  input  logic                reset,
  alarm_annunciator_if.slave  bus
);

  localparam int unsigned BLINK_PER = 2 * BLINK_HALF;
  localparam int unsigned BEEP_PER  = BEEP_ON + BEEP_OFF;
  localparam int unsigned EVT_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WARN     = 2'b01,
    ST_ALARM    = 2'b10,
    ST_SILENCED = 2'b11
  } state_t;

  state_t             state_q, state_n;
  logic [CNT_W-1:0]   blink_q, blink_n;
  logic [CNT_W-1:0]   beep_q, beep_n;
  logic [CNT_W-1:0]   hold_q, hold_n, hold_inc;
  logic               mute_q, mute_n;
  logic               led_q, led_n;
  logic               buzzer_q, buzzer_n;
  logic               siren_q, siren_n;
  logic               hold_done;
  logic               entry;
  logic               alarm_entry;
  state_t             exit_st;

  // Next-state decode; hold_done means this edge completes MIN_SIREN cycles in ALARM
  always_comb begin
    hold_inc  = (hold_q >= CNT_W'(MIN_SIREN)) ? CNT_W'(MIN_SIREN) : hold_q + CNT_W'(1);
    hold_done = (hold_inc >= CNT_W'(MIN_SIREN));
    exit_st   = bus.pre_alarm ? ST_WARN : ST_IDLE;
    state_n   = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.alarm)          state_n = ST_ALARM;
        else if (bus.pre_alarm) state_n = ST_WARN;
      end
      ST_WARN: begin
        if (bus.alarm)           state_n = ST_ALARM;
        else if (!bus.pre_alarm) state_n = ST_IDLE;
      end
      ST_ALARM: begin
        if (!bus.alarm) begin
          if (hold_done) state_n = exit_st;
        end else if (bus.ack && hold_done) begin
          state_n = ST_SILENCED;
        end
      end
      ST_SILENCED: begin
        if (!bus.alarm) state_n = exit_st;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Counter and mute updates: phase counters restart on every state entry
  always_comb begin
    entry       = (state_n != state_q);
    alarm_entry = entry && (state_n == ST_ALARM);
    blink_n     = '0;
    beep_n      = '0;
    hold_n      = '0;
    if (!entry) begin
      blink_n = (blink_q >= CNT_W'(BLINK_PER - 1)) ? '0 : blink_q + CNT_W'(1);
      beep_n  = (beep_q  >= CNT_W'(BEEP_PER - 1))  ? '0 : beep_q  + CNT_W'(1);
    end
    if (state_n == ST_ALARM && !entry) hold_n = hold_inc;
    mute_n = (state_n == ST_WARN) && (state_q == ST_WARN) && (mute_q || bus.ack);
  end

  // Output decode from the state and phase that will hold after this edge
  always_comb begin
    led_n    = 1'b0;
    buzzer_n = 1'b0;
    siren_n  = 1'b0;
    case (state_n)
      ST_WARN: begin
        led_n    = (blink_n < CNT_W'(BLINK_HALF));
        buzzer_n = (beep_n < CNT_W'(BEEP_ON)) && !mute_n;
      end
      ST_ALARM: begin
        led_n   = 1'b1;
        siren_n = 1'b1;
      end
      ST_SILENCED: begin
        led_n = (blink_n < CNT_W'(BLINK_HALF));
      end
      default: begin
        led_n    = 1'b0;
        buzzer_n = 1'b0;
        siren_n  = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any pattern at once
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      blink_q  <= '0;
      beep_q   <= '0;
      hold_q   <= '0;
      mute_q   <= 1'b0;
      led_q    <= 1'b0;
      buzzer_q <= 1'b0;
      siren_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      blink_q  <= blink_n;
      beep_q   <= beep_n;
      hold_q   <= hold_n;
      mute_q   <= mute_n;
      led_q    <= led_n;
      buzzer_q <= buzzer_n;
      siren_q  <= siren_n;
    end
  end

  assign bus.led    = led_q;
  assign bus.buzzer = buzzer_q;
  assign bus.siren  = siren_q;
  assign bus.state  = state_q;

`ifdef ANNUNC_EVENT_COUNT_EN
  logic [EVT_W-1:0] event_q;

  // Saturating count of ALARM entries, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      event_q <= '0;
    end else if (alarm_entry && (event_q != {EVT_W{1'b1}})) begin
      event_q <= event_q + EVT_W'(1);
    end
  end

  assign bus.event_cnt = event_q;
`else
  logic unused_entry;
  assign unused_entry  = alarm_entry;
  assign bus.event_cnt = EVT_W'(0);
`endif

endmodule
